// File: rtl/softex_tcdm_responder.sv
// Multi-port TCDM slave model: shared 64-bit memory, per-port 2-entry response FIFOs.
// Optional pseudo-random grant stalls are enabled with `define SOFTEX_TCDM_RESP_STALL_EN.
module softex_tcdm_responder #(
    parameter int unsigned MP         = 4,
    parameter int unsigned DEPTH      = 1024,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MP-1:0]        tcdm_req_i,
    output logic [MP-1:0]        tcdm_gnt_o,
    input  logic [MP-1:0][31:0]  tcdm_add_i,
    input  logic [MP-1:0]        tcdm_wen_i,
    input  logic [MP-1:0][7:0]   tcdm_be_i,
    input  logic [MP-1:0][63:0]  tcdm_data_i,
    input  logic [MP-1:0][7:0]   tcdm_id_i,
    input  logic [MP-1:0]        tcdm_r_ready_i,
    output logic [MP-1:0][63:0]  tcdm_r_data_o,
    output logic [MP-1:0]        tcdm_r_valid_o,
    output logic                 tcdm_r_opc_o,
    output logic                 tcdm_r_user_o,
    output logic [7:0]           tcdm_r_id_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]           mem_q [DEPTH];
    logic [MP-1:0]         stall;
    logic [MP-1:0]         wr_en;
    logic [MP-1:0][AW-1:0] idx;
    logic                  unused_add;

    assign unused_add    = ^tcdm_add_i;
    assign tcdm_r_opc_o  = 1'b0;
    assign tcdm_r_user_o = 1'b0;

`ifdef SOFTEX_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= STALL_SEED;
        else         lfsr_q <= lfsr_d;
    end

    for (genvar gi = 0; gi < MP; gi++) begin : g_stall
        assign stall[gi] = lfsr_q[gi % 16];
    end
`else
    logic unused_seed;
    assign unused_seed = ^STALL_SEED;
    assign stall       = '0;
`endif

    // Ports are applied in ascending order, so the highest port's bytes land last.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_en[p] && tcdm_be_i[p][b]) begin
                    mem_q[idx[p]][8*b +: 8] <= tcdm_data_i[p][8*b +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < MP; gi++) begin : g_port
        logic [63:0] data_q [2];
        logic [7:0]  id_q   [2];
        logic        wptr_q, wptr_d, rptr_q, rptr_d;
        logic [1:0]  cnt_q, cnt_d;
        logic        push, pop, valid;

        assign idx[gi] = tcdm_add_i[gi][3 +: AW];
        assign valid   = (cnt_q != 2'd0);
        assign pop     = valid & tcdm_r_ready_i[gi];

        // A full FIFO still grants when its head is leaving this cycle.
        assign tcdm_gnt_o[gi] = tcdm_req_i[gi] & ~stall[gi] & ((cnt_q != 2'd2) | pop);
        assign wr_en[gi]      = tcdm_gnt_o[gi] & ~tcdm_wen_i[gi];
        assign push           = tcdm_gnt_o[gi] &  tcdm_wen_i[gi];

        always_comb begin
            wptr_d = wptr_q ^ push;
            rptr_d = rptr_q ^ pop;
            cnt_d  = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + 2'd1;
            end else if (!push && pop) begin
                cnt_d = cnt_q - 2'd1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= 1'b0;
                rptr_q <= 1'b0;
                cnt_q  <= 2'd0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Array read happens before any same-cycle write lands, giving pre-write data.
        always_ff @(posedge clk_i) begin
            if (push) begin
                data_q[wptr_q] <= mem_q[idx[gi]];
                id_q[wptr_q]   <= tcdm_id_i[gi];
            end
        end

        assign tcdm_r_valid_o[gi] = valid;
        assign tcdm_r_data_o[gi]  = valid ? data_q[rptr_q] : 64'd0;

        if (gi == 0) begin : g_id
            assign tcdm_r_id_o = valid ? id_q[rptr_q] : 8'd0;
        end
    end
endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Self-checking bench for softex_tcdm_responder: directed scenarios plus a randomized
// run against a queue/array reference model (stall model active with SOFTEX_TCDM_RESP_STALL_EN).
module tb_softex_tcdm_responder;
    localparam int MP = 4;
    localparam int DEPTH = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [3:0]        req, gnt, wen, rready, rvalid;
    logic [3:0][31:0]  add;
    logic [3:0][7:0]   be, id;
    logic [3:0][63:0]  wdata, rdata;
    logic              opc, user;
    logic [7:0]        rid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        k;
        logic [63:0] d;
        logic [7:0]  id;
    } rsp_t;

    rsp_t        rq [MP][$];
    logic [63:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    logic [15:0] lfsr_m;

    always #5 clk_i = ~clk_i;

    softex_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .STALL_SEED(SEED)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (wdata),
        .tcdm_id_i      (id),
        .tcdm_r_ready_i (rready),
        .tcdm_r_data_o  (rdata),
        .tcdm_r_valid_o (rvalid),
        .tcdm_r_opc_o   (opc),
        .tcdm_r_user_o  (user),
        .tcdm_r_id_o    (rid)
    );

    task automatic idle();
        req = '0; wen = '1; rready = '1; add = '0; be = '0; wdata = '0; id = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_gnt;
        idle();
        rst_ni = 1'b0;
        next_cycle();
        req = 4'b1010;
        #1;
        exp_gnt = 4'b1010;
`ifdef SOFTEX_TCDM_RESP_STALL_EN
        exp_gnt = exp_gnt & ~SEED[3:0];
`endif
        n_tests++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL reset_gnt: got %b expected %b", gnt, exp_gnt); end
        n_tests++; if (rvalid !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_tests++; if (rid !== 8'd0) begin n_fail++; $display("FAIL reset_rid: got %h expected 00", rid); end
        n_tests++; if ({opc, user} !== 2'b00) begin n_fail++; $display("FAIL reset_opc_user: got %b expected 00", {opc, user}); end
        req = '0;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        $display("[TB] reset: done");
    endtask

    task automatic test_basic();
        idle();
        req[0] = 1'b1; wen[0] = 1'b0; add[0] = 32'h40; be[0] = 8'hFF; wdata[0] = 64'h1122334455667788;
        #1;
        n_tests++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL basic_wr_gnt: got %b expected 1", gnt[0]); end
        next_cycle();
        wen[0] = 1'b1; id[0] = 8'd7;
        #1;
        n_tests++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL basic_rd_gnt: got %b expected 1", gnt[0]); end
        n_tests++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_wr_noresp: got %b expected 0", rvalid[0]); end
        next_cycle();
        req = '0;
        #1;
        n_tests++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_latency: rvalid got %b expected 1", rvalid[0]); end
        n_tests++; if (rdata[0] !== 64'h1122334455667788) begin n_fail++; $display("FAIL basic_data: got %h expected 1122334455667788", rdata[0]); end
        n_tests++; if (rid !== 8'd7) begin n_fail++; $display("FAIL basic_id: got %h expected 07", rid); end
        next_cycle();
        n_tests++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_pop: rvalid got %b expected 0", rvalid[0]); end
        $display("[TB] basic: write/read 0x40 done");
    endtask

    task automatic test_byte_enable();
        idle();
        req[1] = 1'b1; wen[1] = 1'b0; add[1] = 32'h0; be[1] = 8'hFF; wdata[1] = 64'h0;
        next_cycle();
        be[1] = 8'h0F; wdata[1] = 64'hFFFFFFFFFFFFFFFF; add[1] = 32'h0000_8000;
        next_cycle();
        wen[1] = 1'b1; add[1] = 32'h0000_0005;
        next_cycle();
        req = '0;
        #1;
        n_tests++; if (rdata[1] !== 64'h00000000FFFFFFFF || rvalid[1] !== 1'b1)
            begin n_fail++; $display("FAIL byte_enable: got %h/%b expected 00000000ffffffff/1", rdata[1], rvalid[1]); end
        next_cycle();
        $display("[TB] byte_enable: be=0F readback done");
    endtask

    task automatic test_back_to_back();
        idle();
        rready[0] = 1'b0; req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h40; id[0] = 8'd1;
        #1;
        n_tests++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b expected 1", gnt[0]); end
        next_cycle();
        id[0] = 8'd2;
        #1;
        n_tests++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt2: got %b expected 1", gnt[0]); end
        n_tests++; if (rid !== 8'd1) begin n_fail++; $display("FAIL b2b_head1: got %h expected 01", rid); end
        next_cycle();
        id[0] = 8'd3;
        #1;
        n_tests++; if (gnt[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_full_gnt: got %b expected 0", gnt[0]); end
        next_cycle();
        rready[0] = 1'b1;
        #1;
        n_tests++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_gnt: got %b expected 1", gnt[0]); end
        n_tests++; if (rid !== 8'd1) begin n_fail++; $display("FAIL b2b_order1: got %h expected 01", rid); end
        next_cycle();
        req = '0; rready[0] = 1'b0;
        #1;
        n_tests++; if (rid !== 8'd2 || rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_order2: got %h/%b expected 02/1", rid, rvalid[0]); end
        next_cycle();
        n_tests++; if (rid !== 8'd2 || rdata[0] !== 64'h1122334455667788)
            begin n_fail++; $display("FAIL b2b_hold: got %h/%h expected 02/1122334455667788", rid, rdata[0]); end
        rready[0] = 1'b1;
        next_cycle();
        n_tests++; if (rid !== 8'd3) begin n_fail++; $display("FAIL b2b_order3: got %h expected 03", rid); end
        next_cycle();
        n_tests++; if (rvalid[0] !== 1'b0 || rid !== 8'd0) begin n_fail++; $display("FAIL b2b_empty: got %b/%h expected 0/00", rvalid[0], rid); end
        $display("[TB] back_to_back: ids 1,2,3 in order");
    endtask

    task automatic test_collision();
        idle();
        req[1] = 1'b1; wen[1] = 1'b0; add[1] = 32'h80; be[1] = 8'hFF; wdata[1] = 64'h0123456789ABCDEF;
        next_cycle();
        idle();
        req = 4'b1101; wen = 4'b0100; add = {4{32'h80}}; be = {4{8'hFF}};
        wdata[0] = 64'hAAAAAAAAAAAAAAAA; wdata[3] = 64'h5555555555555555; id[2] = 8'd9;
        #1;
        n_tests++; if (gnt !== 4'b1101) begin n_fail++; $display("FAIL coll_gnt: got %b expected 1101", gnt); end
        next_cycle();
        idle();
        req[1] = 1'b1; add[1] = 32'h80;
        #1;
        n_tests++; if (rdata[2] !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL coll_old: got %h expected 0123456789abcdef", rdata[2]); end
        next_cycle();
        idle();
        req = 4'b1001; wen = 4'b0000; add = {4{32'h80}}; be[0] = 8'hFF; be[3] = 8'hF0;
        wdata[0] = 64'hAAAAAAAAAAAAAAAA; wdata[3] = 64'h5555555555555555;
        #1;
        n_tests++; if (rdata[1] !== 64'h5555555555555555) begin n_fail++; $display("FAIL coll_winner: got %h expected 5555555555555555", rdata[1]); end
        next_cycle();
        idle();
        req[1] = 1'b1; add[1] = 32'h80;
        next_cycle();
        req = '0;
        #1;
        n_tests++; if (rdata[1] !== 64'h55555555AAAAAAAA) begin n_fail++; $display("FAIL coll_bytes: got %h expected 55555555aaaaaaaa", rdata[1]); end
        next_cycle();
        $display("[TB] collision: port 3 wins, read sees old value");
    endtask

    task automatic test_reset_midop();
        idle();
        rready[1] = 1'b0; req[1] = 1'b1; add[1] = 32'h40;
        next_cycle();
        next_cycle();
        req = '0;
        #1;
        n_tests++; if (rvalid[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_full: rvalid got %b expected 1", rvalid[1]); end
        rst_ni = 1'b0;
        next_cycle();
        n_tests++; if (rvalid !== 4'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 0000", rvalid); end
        rst_ni = 1'b1;
        rready = '1; req[1] = 1'b1;
        next_cycle();
        req = '0;
        #1;
        n_tests++; if (rdata[1] !== 64'h1122334455667788 || rvalid[1] !== 1'b1)
            begin n_fail++; $display("FAIL midrst_mem: got %h/%b expected 1122334455667788/1", rdata[1], rvalid[1]); end
        next_cycle();
        $display("[TB] reset_midop: responses dropped, memory kept");
    endtask

    task automatic test_random(input int cycles);
        logic [3:0] exp_gnt, exp_valid;
        logic [7:0] exp_id;
        logic [5:0] w;
        idle();
        rst_ni = 1'b0;
        for (int p = 0; p < MP; p++) rq[p].delete();
        lfsr_m = SEED;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < MP; p++) begin
                if (c < DEPTH / MP) begin
                    req[p] = 1'b1; wen[p] = 1'b0; be[p] = 8'hFF; rready[p] = 1'b1;
                    add[p] = 32'(((c * MP + p) << 3) | $urandom_range(0, 7));
                end else begin
                    req[p] = ($urandom_range(0, 3) != 0); wen[p] = $urandom_range(0, 1) == 1;
                    be[p] = 8'($urandom); rready[p] = ($urandom_range(0, 3) != 0);
                    add[p] = $urandom;
                end
`ifdef SOFTEX_TCDM_RESP_STALL_EN
                req[p] = 1'b1;
`endif
                wdata[p] = {$urandom, $urandom};
                id[p] = 8'($urandom);
            end
            #1;
            for (int p = 0; p < MP; p++) begin
                exp_valid[p] = rq[p].size() != 0;
                exp_gnt[p] = req[p] && (rq[p].size() < 2 || rready[p]);
`ifdef SOFTEX_TCDM_RESP_STALL_EN
                exp_gnt[p] = exp_gnt[p] && !lfsr_m[p % 16];
`endif
            end
            exp_id = exp_valid[0] ? rq[0][0].id : 8'd0;
            n_tests++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            n_tests++; if (rvalid !== exp_valid) begin n_fail++; $display("FAIL rand_rvalid c%0d: got %b expected %b", c, rvalid, exp_valid); end
            n_tests++; if (rid !== exp_id) begin n_fail++; $display("FAIL rand_rid c%0d: got %h expected %h", c, rid, exp_id); end
            for (int p = 0; p < MP; p++) begin
                if (exp_valid[p] && rq[p][0].k) begin
                    n_tests++;
                    if (rdata[p] !== rq[p][0].d) begin
                        n_fail++; $display("FAIL rand_rdata c%0d p%0d: got %h expected %h", c, p, rdata[p], rq[p][0].d);
                    end
                end
            end
            for (int p = 0; p < MP; p++) begin
                if (exp_valid[p] && rready[p]) void'(rq[p].pop_front());
                w = add[p][8:3];
                if (exp_gnt[p] && wen[p]) rq[p].push_back({known_m[w], mem_m[w], id[p]});
            end
            for (int p = 0; p < MP; p++) begin
                w = add[p][8:3];
                if (exp_gnt[p] && !wen[p]) begin
                    for (int b = 0; b < 8; b++) if (be[p][b]) mem_m[w][8*b +: 8] = wdata[p][8*b +: 8];
                    if (be[p] == 8'hFF) known_m[w] = 1'b1;
                end
            end
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            next_cycle();
        end
        $display("[TB] random: %0d cycles checked against model", cycles);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
        idle();
        rst_ni = 1'b0;
        test_reset();
`ifdef SOFTEX_TCDM_RESP_STALL_EN
        test_random(1000);
`else
        test_basic();
        test_byte_enable();
        test_back_to_back();
        test_collision();
        test_reset_midop();
        test_random(600);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/softex_tcdm_responder.md
SOFTEX_TCDM_RESPONDER -- requirements
Module: softex_tcdm_responder

Interface
REQ-001 SHALL have parameter MP, default 4: number of 64-bit TCDM slave ports.
REQ-002 SHALL have parameter DEPTH, default 1024: number of 64-bit words in the shared memory array; power of two.
REQ-003 SHALL have parameter STALL_SEED, default 16'hACE1: reset value of the stall LFSR, used only with SOFTEX_TCDM_RESP_STALL_EN.
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: tcdm_req_i  in  [MP]  request; tcdm_gnt_o  out  [MP]  grant; tcdm_add_i  in  [MP][32]  byte address; tcdm_wen_i  in  [MP]  1=read, 0=write.
REQ-006 SHALL have ports: tcdm_be_i  in  [MP][8]  byte enables; tcdm_data_i  in  [MP][64]  write data; tcdm_id_i  in  [MP][8]  transaction id; tcdm_r_ready_i  in  [MP]  response accept.
REQ-007 SHALL have ports: tcdm_r_data_o  out  [MP][64]  read data; tcdm_r_valid_o  out  [MP]  response valid; tcdm_r_opc_o  out  1  error flag; tcdm_r_user_o  out  1  user bit; tcdm_r_id_o  out  8  id of port 0 head response.

Function
REQ-008 SHALL use word index add[3 +: log2(DEPTH)]; add[2:0] and bits above the index SHALL be ignored.
REQ-009 SHALL complete a transfer on port p in the cycle req_i[p] && gnt_o[p] is high.
REQ-010 SHALL compute gnt_o[p] combinationally: high when the port-p response buffer has a free entry, counting entries freed by a pop in the same cycle.
REQ-011 SHALL give each port a 2-entry response FIFO holding {data, id}; each accepted read SHALL push one entry.
REQ-012 SHALL not push a response for an accepted write.
REQ-013 SHALL apply an accepted write in the acceptance cycle, updating only bytes whose be bit is 1.
REQ-014 SHALL sample an accepted read from the array in the acceptance cycle and present it the following cycle, giving latency 1 when the FIFO is empty.
REQ-015 SHALL drive tcdm_r_valid_o[p] high whenever FIFO p is non-empty, with r_data_o[p] equal to the head entry.
REQ-016 SHALL pop the head entry when r_valid_o[p] && r_ready_i[p].
REQ-017 SHALL hold head data stable while r_valid_o[p] is high and r_ready_i[p] is low.
REQ-018 SHALL allow a push and a pop in the same cycle on a full FIFO; the occupancy then stays at 2.
REQ-019 SHALL resolve same-cycle writes from several ports to the same word per byte: the highest port index wins.
REQ-020 SHALL return pre-write data when a read and a write hit the same word in the same cycle.
REQ-021 SHALL drive tcdm_r_opc_o = 0 and tcdm_r_user_o = 0 constantly.
REQ-022 SHALL drive tcdm_r_id_o with the port-0 head id, and 0 when FIFO 0 is empty.
REQ-023 SHALL keep the FIFO read/write pointers as 1-bit counters that wrap 1 -> 0, with an occupancy count 0..2.

Reset
REQ-024 SHALL, while rst_ni is low, drive the FIFOs empty, r_valid_o = 0, r_data_o = 0 and r_id_o = 0; gnt_o then follows req_i.
REQ-025 SHALL discard in-flight responses when reset asserts mid-operation; memory array contents SHALL NOT be reset.

Configuration
REQ-026 SHALL, with SOFTEX_TCDM_RESP_STALL_EN defined, hold a 16-bit Fibonacci LFSR (taps 16,14,13,11) reset to STALL_SEED and advanced every cycle.
REQ-027 SHALL, with SOFTEX_TCDM_RESP_STALL_EN defined, force gnt_o[p] low in any cycle where LFSR bit (p mod 16) is 1, in addition to REQ-010.
REQ-028 SHALL, with SOFTEX_TCDM_RESP_STALL_EN undefined, contain no LFSR and drive gnt_o per REQ-010 only.

Verification
REQ-029 SHALL cover: port 0 writes 0x1122334455667788, be=0xFF, to add 0x40, then reads add 0x40 with r_ready=1 -> r_valid one cycle after the grant, data 0x1122334455667788.
REQ-030 SHALL cover: write be=0x0F of 0xFFFFFFFFFFFFFFFF over 0x0 -> readback 0x00000000FFFFFFFF.
REQ-031 SHALL cover: r_ready=0 with three back-to-back reads of id 1,2,3 -> two reads granted, gnt low on the third; after one r_ready pulse, id 3 granted; responses return in order 1,2,3.
REQ-032 SHALL cover: same-cycle writes of 0xAA..AA on port 0 and 0x55..55 on port 3 to the same word -> readback 0x55..55; a same-cycle read returns the old value.
REQ-033 SHALL cover: rst_ni pulsed while a FIFO holds 2 entries -> r_valid=0 the next cycle, and earlier-written memory data still readable.
REQ-034 SHALL cover: with SOFTEX_TCDM_RESP_STALL_EN defined, continuous requests for 1000 cycles -> gnt matches a reference LFSR model, no lost or duplicated response.
